ctrl_hazard: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RV32 core. Sits next to the operand bypass network and decides, every cycle, which stages hold, which pipeline registers receive a bubble, and when a multi-cycle MDU operation is launched. It covers the cases bypassing cannot resolve:
- load-use interlock,
- X-stage redirect flush,
- MDU busy,
- data-memory wait states.

It also keeps a saturating stall-cycle counter.

---
 rtl/ctrl_hazard_pkg.sv | 6 +
 rtl/ctrl_hazard_if.sv | 29 ++
 rtl/ctrl_hazard.sv | 50 +++++
 tb/tb_ctrl_hazard.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ctrl_hazard_pkg.sv
// ctrl_hazard_pkg: shared constants for the hazard/stall controller
package ctrl_hazard_pkg;
    localparam int   RV32_REG_ADDR_WIDTH = 5;
    localparam logic S_RUN = 1'b0;
    localparam logic S_MDU = 1'b1;
endpackage

// File: rtl/ctrl_hazard_if.sv
// ctrl_hazard_if: pipeline-status inputs and stall/bubble/redirect outputs of the hazard controller
interface ctrl_hazard_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic                      i_d_valid, i_d_rs1_rd_sig, i_d_rs2_rd_sig, i_d_is_store;
    logic [REG_ADDR_WIDTH-1:0] i_d_rs1_rd_addr, i_d_rs2_rd_addr;
    logic                      i_x_valid, i_x_is_load, i_x_rd_wr_en, i_x_mdu_req, i_x_redirect;
    logic [REG_ADDR_WIDTH-1:0] i_x_rd_wr_addr;
    logic                      i_mdu_done, i_m_dmem_req, i_m_dmem_ack;
    logic                      o_f_stall, o_d_stall, o_x_stall, o_m_stall;
    logic                      o_x_bubble, o_m_bubble, o_w_bubble;
    logic                      o_d_flush, o_pc_redirect_en, o_mdu_start;
    logic [CNT_WIDTH-1:0]      o_stall_cnt;
    modport master (
        output i_d_valid, i_d_rs1_rd_sig, i_d_rs2_rd_sig, i_d_is_store, i_d_rs1_rd_addr, i_d_rs2_rd_addr,
               i_x_valid, i_x_is_load, i_x_rd_wr_en, i_x_mdu_req, i_x_redirect, i_x_rd_wr_addr,
               i_mdu_done, i_m_dmem_req, i_m_dmem_ack,
        input  o_f_stall, o_d_stall, o_x_stall, o_m_stall, o_x_bubble, o_m_bubble, o_w_bubble,
               o_d_flush, o_pc_redirect_en, o_mdu_start, o_stall_cnt
    );
    modport slave (
        input  i_d_valid, i_d_rs1_rd_sig, i_d_rs2_rd_sig, i_d_is_store, i_d_rs1_rd_addr, i_d_rs2_rd_addr,
               i_x_valid, i_x_is_load, i_x_rd_wr_en, i_x_mdu_req, i_x_redirect, i_x_rd_wr_addr,
               i_mdu_done, i_m_dmem_req, i_m_dmem_ack,
        output o_f_stall, o_d_stall, o_x_stall, o_m_stall, o_x_bubble, o_m_bubble, o_w_bubble,
               o_d_flush, o_pc_redirect_en, o_mdu_start, o_stall_cnt
    );
endinterface

// File: rtl/ctrl_hazard.sv
// ctrl_hazard: load-use / redirect / MDU / dmem-wait stall controller with saturating stall counter
module ctrl_hazard
    import ctrl_hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = RV32_REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    ctrl_hazard_if.slave bus
);
    logic                 state, done_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 mem_stall, mdu_fin, mdu_busy, lu_hazard, mdu_go, mdu_exit;
    always_comb begin
        mem_stall = bus.i_m_dmem_req & ~bus.i_m_dmem_ack;
        // a done pulse only counts while an MDU op is actually in flight
        mdu_fin   = (state == S_MDU) & (bus.i_mdu_done | done_q);
        mdu_busy  = bus.i_x_valid & bus.i_x_mdu_req & ~mdu_fin;
        lu_hazard = bus.i_x_valid & bus.i_x_is_load & bus.i_x_rd_wr_en &
                    (bus.i_x_rd_wr_addr != REG_ADDR_WIDTH'(0)) & bus.i_d_valid &
                    ((bus.i_d_rs1_rd_sig & (bus.i_d_rs1_rd_addr == bus.i_x_rd_wr_addr)) |
                     (bus.i_d_rs2_rd_sig & (bus.i_d_rs2_rd_addr == bus.i_x_rd_wr_addr) & ~bus.i_d_is_store));
        mdu_go    = (state == S_RUN) & bus.i_x_valid & bus.i_x_mdu_req & ~mem_stall;
        mdu_exit  = (state == S_MDU) & mdu_fin & ~mem_stall;
    end
    assign bus.o_m_stall        = mem_stall;
    assign bus.o_w_bubble       = mem_stall;
    assign bus.o_x_stall        = mem_stall | mdu_busy;
    assign bus.o_m_bubble       = mdu_busy & ~mem_stall;
    assign bus.o_f_stall        = bus.o_x_stall | (lu_hazard & ~bus.i_x_redirect);
    assign bus.o_d_stall        = bus.o_f_stall;
    assign bus.o_x_bubble       = ~bus.o_x_stall & (bus.i_x_redirect | lu_hazard);
    assign bus.o_d_flush        = ~bus.o_x_stall & bus.i_x_redirect;
    assign bus.o_pc_redirect_en = bus.o_d_flush;
    assign bus.o_mdu_start      = mdu_go & i_rst_n;
    assign bus.o_stall_cnt      = cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_RUN;
            done_q <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= mdu_go ? S_MDU : mdu_exit ? S_RUN : state;
            // remember a done that lands while M is waiting on memory
            done_q <= (state == S_MDU) & ~mdu_exit & (done_q | (bus.i_mdu_done & mem_stall));
            if (bus.o_f_stall && !(&cnt)) cnt <= cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_ctrl_hazard.sv
// tb_ctrl_hazard: directed vectors with hand-computed expectations, checked by a scoreboard monitor
module tb_ctrl_hazard;
    localparam logic [9:0] FS = 10'b1000000000, DS = 10'b0100000000, XS = 10'b0010000000,
                           MS = 10'b0001000000, XB = 10'b0000100000, MB = 10'b0000010000,
                           WB = 10'b0000001000, DF = 10'b0000000100, PR = 10'b0000000010,
                           ST = 10'b0000000001, ZZ = 10'b0000000000;
    localparam logic [9:0] MDU_RUN = FS | DS | XS | MB;
    localparam logic [9:0] MEM_W   = FS | DS | XS | MS | WB;
    localparam logic [9:0] REDIR   = XB | DF | PR;
    typedef struct packed {
        logic [9:0]  f;
        logic [31:0] cnt;
        int          sat;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    ctrl_hazard_if bus ();
    ctrl_hazard_if #(.CNT_WIDTH(2)) sbus ();
    ctrl_hazard dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
    ctrl_hazard #(.CNT_WIDTH(2)) sat_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(sbus.slave));
    // second instance stalls on memory every cycle so its narrow counter saturates quickly
    assign sbus.i_d_valid = 1'b0, sbus.i_d_rs1_rd_sig = 1'b0, sbus.i_d_rs2_rd_sig = 1'b0,
           sbus.i_d_is_store = 1'b0, sbus.i_d_rs1_rd_addr = '0, sbus.i_d_rs2_rd_addr = '0,
           sbus.i_x_valid = 1'b0, sbus.i_x_is_load = 1'b0, sbus.i_x_rd_wr_en = 1'b0,
           sbus.i_x_mdu_req = 1'b0, sbus.i_x_redirect = 1'b0, sbus.i_x_rd_wr_addr = '0,
           sbus.i_mdu_done = 1'b0, sbus.i_m_dmem_req = 1'b1, sbus.i_m_dmem_ack = 1'b0;
    exp_t q[$];
    exp_t e;
    int total = 0;
    int bad = 0;
    int step = 0;
    logic [9:0] got;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            step++;
            got = {bus.o_f_stall, bus.o_d_stall, bus.o_x_stall, bus.o_m_stall, bus.o_x_bubble,
                   bus.o_m_bubble, bus.o_w_bubble, bus.o_d_flush, bus.o_pc_redirect_en, bus.o_mdu_start};
            total++;
            if (got !== e.f) begin
                bad++;
                $display("FAIL step%0d flags[f d x m xb mb wb fl pr st] got=%b want=%b", step, got, e.f);
            end
            total++;
            if (bus.o_stall_cnt !== e.cnt) begin
                bad++;
                $display("FAIL step%0d stall_cnt got=%0d want=%0d", step, bus.o_stall_cnt, e.cnt);
            end
            if (e.sat >= 0) begin
                total++;
                if (sbus.o_stall_cnt !== 2'(e.sat)) begin
                    bad++;
                    $display("FAIL step%0d sat_cnt got=%0d want=%0d", step, sbus.o_stall_cnt, e.sat);
                end
            end
        end
    end
    task automatic idle();
        bus.i_d_valid = 0; bus.i_d_rs1_rd_sig = 0; bus.i_d_rs2_rd_sig = 0; bus.i_d_is_store = 0;
        bus.i_d_rs1_rd_addr = '0; bus.i_d_rs2_rd_addr = '0;
        bus.i_x_valid = 0; bus.i_x_is_load = 0; bus.i_x_rd_wr_en = 0; bus.i_x_mdu_req = 0;
        bus.i_x_redirect = 0; bus.i_x_rd_wr_addr = '0;
        bus.i_mdu_done = 0; bus.i_m_dmem_req = 0; bus.i_m_dmem_ack = 0;
    endtask
    task automatic ld(input logic [4:0] rd);
        bus.i_x_valid = 1; bus.i_x_is_load = 1; bus.i_x_rd_wr_en = 1; bus.i_x_rd_wr_addr = rd;
    endtask
    task automatic dset(input logic s1, input logic [4:0] r1, input logic s2, input logic [4:0] r2, input logic st);
        bus.i_d_valid = 1; bus.i_d_rs1_rd_sig = s1; bus.i_d_rs1_rd_addr = r1;
        bus.i_d_rs2_rd_sig = s2; bus.i_d_rs2_rd_addr = r2; bus.i_d_is_store = st;
    endtask
    task automatic mdu();
        bus.i_x_valid = 1; bus.i_x_mdu_req = 1;
    endtask
    task automatic cyc(input logic [9:0] f, input int c, input int s);
        q.push_back('{f: f, cnt: 32'(c), sat: s});
        @(posedge clk);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        idle();
        @(posedge clk);
        #1;
        mdu(); cyc(MDU_RUN, 0, 0);
        rst_n = 1;
        idle(); cyc(ZZ, 0, -1);
        idle(); ld(5); dset(1, 5, 1, 1, 0); cyc(FS | DS | XB, 0, -1);
        idle(); cyc(ZZ, 1, -1);
        idle(); ld(5); dset(1, 2, 1, 5, 1); cyc(ZZ, 1, -1);
        idle(); ld(5); dset(1, 5, 1, 1, 1); cyc(FS | DS | XB, 1, -1);
        idle(); ld(0); dset(1, 0, 1, 0, 0); cyc(ZZ, 2, -1);
        idle(); ld(5); dset(1, 5, 0, 0, 0); bus.i_x_redirect = 1; cyc(REDIR, 2, -1);
        idle(); bus.i_x_valid = 1; bus.i_x_redirect = 1; cyc(REDIR, 2, -1);
        idle(); mdu(); cyc(MDU_RUN | ST, 2, -1);
        cyc(MDU_RUN, 3, -1);
        cyc(MDU_RUN, 4, -1);
        cyc(MDU_RUN, 5, -1);
        bus.i_mdu_done = 1; cyc(ZZ, 6, -1);
        idle(); cyc(ZZ, 6, -1);
        idle(); mdu(); cyc(MDU_RUN | ST, 6, -1);
        bus.i_m_dmem_req = 1; bus.i_mdu_done = 1; cyc(MEM_W, 7, -1);
        bus.i_mdu_done = 0; cyc(MEM_W, 8, -1);
        cyc(MEM_W, 9, -1);
        bus.i_m_dmem_ack = 1; cyc(ZZ, 10, -1);
        idle(); cyc(ZZ, 10, -1);
        idle(); mdu(); bus.i_m_dmem_req = 1; cyc(MEM_W, 10, -1);
        bus.i_m_dmem_ack = 1; cyc(MDU_RUN | ST, 11, -1);
        bus.i_m_dmem_req = 0; bus.i_m_dmem_ack = 0; cyc(MDU_RUN, 12, -1);
        bus.i_m_dmem_req = 1; bus.i_mdu_done = 1; cyc(MEM_W, 13, -1);
        bus.i_m_dmem_req = 0; bus.i_mdu_done = 0; rst_n = 0; cyc(MDU_RUN, 0, 0);
        rst_n = 1; cyc(MDU_RUN | ST, 0, 0);
        bus.i_mdu_done = 1; cyc(ZZ, 1, 1);
        cyc(MDU_RUN | ST, 1, 2);
        cyc(ZZ, 2, 3);
        idle(); bus.i_x_valid = 1; bus.i_x_redirect = 1; bus.i_m_dmem_req = 1; cyc(MEM_W, 2, 3);
        bus.i_m_dmem_ack = 1; cyc(REDIR, 3, 3);
        idle(); cyc(ZZ, 3, 3);
        cyc(ZZ, 3, 3);
        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
